// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO burst drain.
package fifo_drain_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_PAD_WORD = 16'hDEAD;

endpackage

// File: rtl/drain_out_reg.sv
// Registered valid/ready output stage; the payload is held while a beat is stalled.
module drain_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_sop,
    input  logic                  load_eop,
    input  logic                  m_ready,
    output logic                  out_free,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop
);

    assign out_free = !m_valid || m_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
        end else if (out_free) begin
            m_valid <= load;
            if (load) begin
                m_data <= load_data;
                m_sop  <= load_sop;
                m_eop  <= load_eop;
            end
        end
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains a FIFO into fixed-length sop/eop framed packets, padding on a dry FIFO.
// Define BURST_DRAIN_CHECKSUM_EN to append an XOR checksum beat to each packet.
module fifo_burst_drain
    import fifo_drain_pkg::*;
#(
    parameter int                     DATA_WIDTH = 16,
    parameter int                     BURST_LEN  = 4,
    parameter int                     TIMEOUT    = 8,
    parameter logic [DATA_WIDTH-1:0]  PAD_WORD   = DATA_WIDTH'(DEFAULT_PAD_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_LEN);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

`ifdef BURST_DRAIN_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    // After the final data/pad beat we either close the packet or append the checksum.
    localparam state_t DONE_STATE = CSUM_ON ? CSUM : IDLE;

    state_t                state;
    logic [CW-1:0]         beat_cnt;
    logic [CW-1:0]         beat_next;
    logic [TW-1:0]         to_cnt;
    logic                  out_free;
    logic                  last_beat;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_sop;
    logic                  load_eop;
`ifdef BURST_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;
`endif

    assign fifo_rd   = (state == IDLE || state == DATA) && !fifo_empty && out_free && !reset;
    assign beat_next = (state == IDLE) ? CW'(1) : beat_cnt + CW'(1);
    assign last_beat = (beat_next == BEAT_LAST);

    always_comb begin
        load      = 1'b0;
        load_data = fifo_data;
        load_sop  = 1'b0;
        load_eop  = 1'b0;
        case (state)
            IDLE, DATA: begin
                load     = fifo_rd;
                load_sop = (state == IDLE);
                load_eop = last_beat && !CSUM_ON;
            end
            PAD: begin
                load      = out_free;
                load_data = PAD_WORD;
                load_eop  = last_beat && !CSUM_ON;
            end
            default: begin
`ifdef BURST_DRAIN_CHECKSUM_EN
                load      = out_free;
                load_data = checksum;
                load_eop  = 1'b1;
`endif
            end
        endcase
    end

    // The timeout only runs while mid-packet, the FIFO is dry and the output could take a beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_rd) begin
                        beat_cnt <= beat_next;
                        to_cnt   <= '0;
                        state    <= last_beat ? DONE_STATE : DATA;
                    end
                end
                DATA: begin
                    if (fifo_rd) begin
                        beat_cnt <= beat_next;
                        to_cnt   <= '0;
                        if (last_beat) state <= DONE_STATE;
                    end else if (fifo_empty && out_free) begin
                        if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + TW'(1);
                        if (to_cnt == TO_LAST) state <= PAD;
                    end
                end
                PAD: begin
                    to_cnt <= '0;
                    if (out_free) begin
                        beat_cnt <= beat_next;
                        if (last_beat) state <= DONE_STATE;
                    end
                end
                default: begin
                    if (out_free) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef BURST_DRAIN_CHECKSUM_EN
    // A sop beat restarts the running XOR so the checksum covers exactly one packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (load && state != CSUM) begin
            checksum <= load_sop ? load_data : (checksum ^ load_data);
        end
    end
`endif

    drain_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(load_data),
        .load_sop (load_sop),
        .load_eop (load_eop),
        .m_ready  (m_ready),
        .out_free (out_free),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_sop    (m_sop),
        .m_eop    (m_eop)
    );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Testbench for fifo_burst_drain: directed vector tables plus a randomized run against a packet model.
module tb_fifo_burst_drain;

    localparam int          DW   = 16;
    localparam int          BL   = 4;
    localparam int          TO   = 8;
    localparam logic [15:0] PADW = 16'hDEAD;
`ifdef BURST_DRAIN_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        empty;
        logic [15:0] data;
        logic        ready;
        logic        exp_rd;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_sop;
        logic        exp_eop;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .TIMEOUT   (TO),
        .PAD_WORD  (PADW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sop     (m_sop),
        .m_eop     (m_eop)
    );

    task automatic addVec(input logic e, input logic [15:0] d, input logic r, input logic rd,
                          input logic v, input logic [15:0] xd, input logic s, input logic eo);
        vec_t t;
        t.empty = e; t.data = d; t.ready = r; t.exp_rd = rd;
        t.exp_valid = v; t.exp_data = xd; t.exp_sop = s; t.exp_eop = eo;
        vecs.push_back(t);
    endtask

    // Payload is only meaningful while m_valid is expected high.
    task automatic checkOutput(input string name, input logic act_rd, input logic exp_rd,
                               input logic exp_v, input logic [15:0] exp_d,
                               input logic exp_s, input logic exp_e);
        bit ok;
        vectors++;
        ok = (act_rd === exp_rd) && (m_valid === exp_v);
        if (exp_v) ok = ok && (m_data === exp_d) && (m_sop === exp_s) && (m_eop === exp_e);
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got rd=%0b v=%0b d=%h sop=%0b eop=%0b, want rd=%0b v=%0b d=%h sop=%0b eop=%0b",
                     name, $time, act_rd, m_valid, m_data, m_sop, m_eop,
                     exp_rd, exp_v, exp_d, exp_s, exp_e);
        end
    endtask

    task automatic checkReset(input string name);
        vectors++;
        if (m_valid !== 1'b0 || m_data !== 16'h0 || m_sop !== 1'b0 || m_eop !== 1'b0 || fifo_rd !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s: got rd=%0b v=%0b d=%h sop=%0b eop=%0b, want all zero",
                     name, fifo_rd, m_valid, m_data, m_sop, m_eop);
        end
    endtask

    task automatic applyStimulus(input string name, input vec_t v);
        logic rd;
        fifo_empty = v.empty;
        fifo_data  = v.data;
        m_ready    = v.ready;
        #2;
        rd = fifo_rd;
        @(posedge clk);
        #1;
        checkOutput(name, rd, v.exp_rd, v.exp_valid, v.exp_data, v.exp_sop, v.exp_eop);
    endtask

    task automatic runTable(input string name);
        foreach (vecs[i]) applyStimulus(name, vecs[i]);
        vecs.delete();
    endtask

    task automatic doReset(input string name);
        fifo_empty = 1'b1;
        fifo_data  = 16'h0;
        m_ready    = 1'b1;
        reset      = 1'b1;
        #1;
        checkReset(name);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: position of the packet being built plus a dry-cycle tally.
    logic [15:0] fq[$];
    int          pos, idle, phase_left;
    bit          padding, csum_p, dry;
    logic        mv, ms, me;
    logic [15:0] md, xs;

    initial begin
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 16'h0;
        m_ready    = 1'b1;
        #1;
        doReset("reset_state");

`ifndef BURST_DRAIN_CHECKSUM_EN
        // Two back-to-back packets at full rate.
        for (int i = 1; i <= 8; i++)
            addVec(1'b0, 16'(i), 1'b1, 1'b1, 1'b1, 16'(i), (i == 1 || i == 5), (i == 4 || i == 8));
        addVec(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        runTable("burst_full_rate");
        doReset("reset_t2");

        // Stall after first beat: payload held, no pops.
        addVec(1'b0, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            addVec(1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        for (int i = 2; i <= 4; i++)
            addVec(1'b0, 16'(i), 1'b1, 1'b1, 1'b1, 16'(i), 1'b0, (i == 4));
        addVec(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        runTable("stall_hold");
        doReset("reset_t3");

        // Dry FIFO mid-packet pads after TIMEOUT cycles and ignores new data while padding.
        addVec(1'b0, 16'h00A1, 1'b1, 1'b1, 1'b1, 16'h00A1, 1'b1, 1'b0);
        addVec(1'b0, 16'h00A2, 1'b1, 1'b1, 1'b1, 16'h00A2, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++)
            addVec(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        addVec(1'b0, 16'h00EE, 1'b1, 1'b0, 1'b1, PADW, 1'b0, 1'b0);
        addVec(1'b0, 16'h00EE, 1'b1, 1'b0, 1'b1, PADW, 1'b0, 1'b1);
        addVec(1'b0, 16'h00EE, 1'b1, 1'b1, 1'b1, 16'h00EE, 1'b1, 1'b0);
        runTable("timeout_pad");
        doReset("reset_t4");

        // Data arriving one cycle before expiry clears the timer.
        addVec(1'b0, 16'h00B1, 1'b1, 1'b1, 1'b1, 16'h00B1, 1'b1, 1'b0);
        for (int i = 0; i < TO - 1; i++)
            addVec(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        addVec(1'b0, 16'h00B2, 1'b1, 1'b1, 1'b1, 16'h00B2, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++)
            addVec(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        addVec(1'b0, 16'h00B3, 1'b1, 1'b1, 1'b1, 16'h00B3, 1'b0, 1'b0);
        addVec(1'b0, 16'h00B4, 1'b1, 1'b1, 1'b1, 16'h00B4, 1'b0, 1'b1);
        addVec(1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        runTable("timer_clear");
        doReset("reset_t5");
`else
        // Checksum beat follows the fourth data beat.
        addVec(1'b0, 16'h0F0F, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0);
        addVec(1'b0, 16'h00FF, 1'b1, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0);
        addVec(1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        addVec(1'b0, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        addVec(1'b0, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h1DC5, 1'b0, 1'b1);
        addVec(1'b0, 16'h5555, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
        runTable("checksum_beat");
        doReset("reset_t6");
`endif

        // Reset mid-packet: outputs clear at once and the next word starts a new packet.
        addVec(1'b0, 16'h00C1, 1'b1, 1'b1, 1'b1, 16'h00C1, 1'b1, 1'b0);
        addVec(1'b0, 16'h00C2, 1'b1, 1'b1, 1'b1, 16'h00C2, 1'b0, 1'b0);
        runTable("pre_reset");
        fifo_empty = 1'b0;
        fifo_data  = 16'h00C3;
        m_ready    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkReset("async_reset_mid_packet");
        @(posedge clk);
        #1;
        reset = 1'b0;
        addVec(1'b0, 16'h00D1, 1'b1, 1'b1, 1'b1, 16'h00D1, 1'b1, 1'b0);
        addVec(1'b0, 16'h00D2, 1'b1, 1'b1, 1'b1, 16'h00D2, 1'b0, 1'b0);
        runTable("post_reset");
        doReset("reset_random");

        // Randomized traffic against the packet model.
        pos = 0; idle = 0; padding = 0; csum_p = 0; phase_left = 0; dry = 0;
        mv = 0; md = 16'h0; ms = 0; me = 0; xs = 16'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, e, free, pop, counting, act_rd;
            logic [15:0] d, w;
            if (phase_left == 0) begin
                dry        = ($urandom_range(0, 2) == 0);
                phase_left = $urandom_range(3, 25);
            end
            phase_left--;
            if (!dry && $urandom_range(0, 3) != 0) fq.push_back(16'($urandom));
            r = ($urandom_range(0, 4) != 0);
            e = (fq.size() == 0);
            d = e ? 16'h0 : fq[0];

            free     = !mv || r;
            pop      = !padding && !csum_p && !e && free;
            counting = (pos > 0) && !padding && !csum_p && e && free;
            if (free) begin
                if (pop || padding) begin
                    w   = pop ? d : PADW;
                    pos = pos + 1;
                    mv  = 1'b1; md = w; ms = (pos == 1); me = (pos == BL) && !CSUM_ON;
                    xs  = (pos == 1) ? w : (xs ^ w);
                    if (pos == BL) begin
                        pos = 0; padding = 0;
                        if (CSUM_ON) csum_p = 1;
                    end
                end else if (csum_p) begin
                    mv = 1'b1; md = xs; ms = 1'b0; me = 1'b1; csum_p = 0;
                end else begin
                    mv = 1'b0;
                end
            end
            if (pop) idle = 0;
            else if (counting) begin
                idle++;
                if (idle == TO) begin padding = 1; idle = 0; end
            end

            fifo_empty = e;
            fifo_data  = d;
            m_ready    = r;
            #2;
            act_rd = fifo_rd;
            @(posedge clk);
            #1;
            if (act_rd && fq.size() > 0) void'(fq.pop_front());
            checkOutput("random", act_rd, pop, mv, md, ms, me);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
